// File: rtl/branch_pkg.sv
// Shared types and constants for the fetch-side branch bookkeeping logic.
package branch_pkg;

  // Address width of a queued branch entry. It matches the default top-level XLEN.
  localparam int BR_XLEN = 32;

  // Fixed instruction size. The fall-through PC is pc + INSTR_BYTES.
  localparam int INSTR_BYTES = 4;

  // Width of the saturating mispredict counter.
  localparam int MISP_CNT_W = 16;

  // One in-flight predicted branch: where it was fetched and what was predicted.
  typedef struct packed {
    logic [BR_XLEN-1:0] br_pc;
    logic               pred_taken;
    logic [BR_XLEN-1:0] pred_target;
  } br_entry_t;

endpackage

// File: rtl/branch_queue.sv
// Circular FIFO of in-flight predicted branches. It supports synchronous clear,
// push and pop. Clear wins over push and pop in the same cycle.
module branch_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  br_entry_t                i_wdata,
  output br_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  br_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full queue or a pop from an empty one has no effect.
  assign w_wr = i_push & ~o_full  & ~i_clr;
  assign w_rd = i_pop  & ~o_empty & ~i_clr;

  // Entry storage. It is not reset: the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Update the pointers and the count. A power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_recovery_unit.sv
// Fetch PC sequencer. It follows predictions, keeps in-flight branches in order,
// detects mispredictions at resolve time, and then redirects, flushes and trains.
module branch_recovery_unit
  import branch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            fetch_valid,
  input  logic            fetch_branch,
  input  logic            prediction,
  input  logic [XLEN-1:0] pred_target,
  input  logic            resolve_valid,
  input  logic            resolve_taken,
  input  logic [XLEN-1:0] resolve_target,
  output logic [XLEN-1:0] pc,
  output logic            stall,
  output logic            flush,
  output logic            branch,
  output logic            branch_taken,
  output logic [15:0]     mispredict_count
);

  localparam int PTR_W = $clog2(DEPTH);

  // The counter holds at all-ones instead of wrapping.
  function automatic logic [MISP_CNT_W-1:0] sat_inc(input logic [MISP_CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  logic [XLEN-1:0]       r_pc;
  logic                  r_flush;
  logic                  r_branch;
  logic                  r_br_taken;
  logic [MISP_CNT_W-1:0] r_misp_cnt;

  br_entry_t             w_head;
  br_entry_t             w_wentry;
  logic [PTR_W:0]        w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_resolve;
  logic                  w_misp;
  logic                  w_push;
  logic [XLEN-1:0]       w_pc_nxt;

  // Stall comes from the registered count only, so a same-cycle pop does not release it.
  assign stall = (w_count == (PTR_W+1)'(DEPTH));

  // A resolve arriving while nothing is in flight is ignored.
  assign w_resolve = resolve_valid & ~w_empty;

  // Wrong direction, or taken to a different target than predicted.
  assign w_misp = w_resolve &
                  ((resolve_taken != w_head.pred_taken) |
                   (resolve_taken & (resolve_target != w_head.pred_target)));

  // Never record a branch fetched on the cycle a mispredict squashes the queue.
  assign w_push = fetch_valid & fetch_branch & ~w_full & ~w_misp;

  assign w_wentry.br_pc       = r_pc;
  assign w_wentry.pred_taken  = prediction;
  assign w_wentry.pred_target = pred_target;

  branch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_clr   (w_misp),
    .i_push  (w_push),
    .i_pop   (w_resolve),
    .i_wdata (w_wentry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next PC: recovery beats the fetch stream; a stalled or idle fetch holds.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_misp) begin
      w_pc_nxt = resolve_taken ? resolve_target : (w_head.br_pc + XLEN'(INSTR_BYTES));
    end else if (fetch_valid & ~stall) begin
      w_pc_nxt = (fetch_branch & prediction) ? pred_target : (r_pc + XLEN'(INSTR_BYTES));
    end
  end

  // PC register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_pc <= RESET_PC;
    else          r_pc <= w_pc_nxt;
  end

  // One-cycle flush and training pulses, plus the saturating mispredict counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_flush    <= 1'b0;
      r_branch   <= 1'b0;
      r_br_taken <= 1'b0;
      r_misp_cnt <= '0;
    end else begin
      r_flush    <= w_misp;
      r_branch   <= w_resolve;
      r_br_taken <= w_resolve & resolve_taken;
      if (w_misp) r_misp_cnt <= sat_inc(r_misp_cnt);
    end
  end

  assign pc               = r_pc;
  assign flush            = r_flush;
  assign branch           = r_branch;
  assign branch_taken     = r_br_taken;
  assign mispredict_count = r_misp_cnt;

endmodule
